mem_port_arbiter: RTL and testbench

//  Shares the single host port of the BIST-capable memory controller between two requesters
//  (R0, R1) and schedules BIST sessions on the same port.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, BIST and controller signal bundle around the host port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] rdata;
  logic          bist_req;
  logic [2:0]    bist_mode_in;
  logic          bist_done;
  logic          bist_ok;
  logic [AW-1:0] addr;
  logic [DW-1:0] idata;
  logic          ce;
  logic          csb;
  logic          web;
  logic          oeb;
  logic          bist_en;
  logic [2:0]    bist_mode;
  logic [DW-1:0] odata;
  logic          bist_pass;

  modport master (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  bist_req, bist_mode_in, odata, bist_pass,
    output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
    output bist_done, bist_ok,
    output addr, idata, ce, csb, web, oeb, bist_en, bist_mode
  );

  modport slave (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output bist_req, bist_mode_in, odata, bist_pass,
    input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
    input  bist_done, bist_ok,
    input  addr, idata, ce, csb, web, oeb, bist_en, bist_mode
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the memory controller host port between R0/R1 and schedules BIST sessions
// MEMARB_FIXED_PRI_EN: when defined R0 always wins a tie; otherwise round-robin.
module mem_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RDWAIT   = 2'd2,
    BIST_RUN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;    // 1: R1 was granted most recently
  logic          owner_q, owner_d;  // requester owning the access in flight
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ce_q, ce_d, csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] idata_q, idata_d, rdata_q, rdata_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d, rv0_q, rv0_d, rv1_q, rv1_d;
  logic          done_q, done_d, ok_q, ok_d, bist_en_q, bist_en_d;
  logic [2:0]    bist_mode_q, bist_mode_d;

  logic          pick_r1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    pick_r1 = bus.r1_req;
    if (bus.r0_req && bus.r1_req) begin
`ifdef MEMARB_FIXED_PRI_EN
      pick_r1 = 1'b0;
`else
      pick_r1 = ~last_q;
`endif
    end
    sel_we    = pick_r1 ? bus.r1_we    : bus.r0_we;
    sel_addr  = pick_r1 ? bus.r1_addr  : bus.r0_addr;
    sel_wdata = pick_r1 ? bus.r1_wdata : bus.r0_wdata;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    ce_d        = 1'b0;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    oeb_d       = 1'b1;
    addr_d      = addr_q;
    idata_d     = idata_q;
    rdata_d     = rdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rv0_d       = 1'b0;
    rv1_d       = 1'b0;
    done_d      = 1'b0;
    ok_d        = ok_q;
    bist_en_d   = 1'b0;
    bist_mode_d = 3'b000;

    case (state_q)
      IDLE: begin
        if (bus.bist_req) begin
          state_d     = BIST_RUN;
          bist_en_d   = 1'b1;
          bist_mode_d = bus.bist_mode_in;
        end else if (bus.r0_req || bus.r1_req) begin
          state_d = ACCESS;
          owner_d = pick_r1;
          last_d  = pick_r1;
          we_d    = sel_we;
          ce_d    = 1'b1;
          csb_d   = 1'b0;
          addr_d  = sel_addr;
          web_d   = ~sel_we;
          oeb_d   = sel_we;
          if (sel_we) begin
            idata_d = sel_wdata;
          end
          gnt0_d = ~pick_r1;
          gnt1_d = pick_r1;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
          oeb_d   = 1'b0;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      RDWAIT: begin
        if (cnt_q == '0) begin
          // last wait cycle: ODATA is captured on this edge
          state_d = IDLE;
          rdata_d = bus.odata;
          rv0_d   = ~owner_q;
          rv1_d   = owner_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
          oeb_d = 1'b0;
        end
      end
      BIST_RUN: begin
        if (bus.bist_req) begin
          bist_en_d   = 1'b1;
          bist_mode_d = bus.bist_mode_in;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          ok_d    = bus.bist_pass;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      addr_q      <= '0;
      idata_q     <= '0;
      rdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rv0_q       <= 1'b0;
      rv1_q       <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      bist_en_q   <= 1'b0;
      bist_mode_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      addr_q      <= addr_d;
      idata_q     <= idata_d;
      rdata_q     <= rdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rv0_q       <= rv0_d;
      rv1_q       <= rv1_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      bist_en_q   <= bist_en_d;
      bist_mode_q <= bist_mode_d;
    end
  end

  assign bus.ce        = ce_q;
  assign bus.csb       = csb_q;
  assign bus.web       = web_q;
  assign bus.oeb       = oeb_q;
  assign bus.addr      = addr_q;
  assign bus.idata     = idata_q;
  assign bus.rdata     = rdata_q;
  assign bus.r0_gnt    = gnt0_q;
  assign bus.r1_gnt    = gnt1_q;
  assign bus.r0_rvalid = rv0_q;
  assign bus.r1_rvalid = rv1_q;
  assign bus.bist_done = done_q;
  assign bus.bist_ok   = ok_q;
  assign bus.bist_en   = bist_en_q;
  assign bus.bist_mode = bist_mode_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (RD_LAT=1 and RD_LAT=3 instances)
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.AW(16), .DW(8)) bus ();
  mem_port_arbiter_if #(.AW(16), .DW(8)) bus3 ();

  mem_port_arbiter #(.AW(16), .DW(8), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_port_arbiter #(.AW(16), .DW(8), .RD_LAT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // controller model: writes on strobed edge, read address latched at the read strobe
  logic [7:0] mem [256];
  logic [7:0] rd_addr;
  always @(posedge clk) begin
    if (bus.ce && !bus.csb && !bus.web) mem[bus.addr[7:0]] <= bus.idata;
    if (bus.ce && !bus.csb && bus.web) rd_addr <= bus.addr[7:0];
  end
  assign bus.odata  = mem[rd_addr];
  assign bus3.odata = 8'hC3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int   ng;
  int   nv;
  logic exp_r1;
  logic q [$];

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    rd_addr = 8'h00;
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = 16'h0020; bus.r1_wdata = '0;
    bus.bist_req = 0; bus.bist_mode_in = 3'b000; bus.bist_pass = 0;
    bus3.r0_req = 0; bus3.r0_we = 0; bus3.r0_addr = '0; bus3.r0_wdata = '0;
    bus3.r1_req = 0; bus3.r1_we = 0; bus3.r1_addr = 16'h0040; bus3.r1_wdata = '0;
    bus3.bist_req = 0; bus3.bist_mode_in = 3'b000; bus3.bist_pass = 0;
    reset_dut();

    // reset state
    chk("rst_ce", bus.ce, 0);
    chk("rst_csb", bus.csb, 1);
    chk("rst_web", bus.web, 1);
    chk("rst_oeb", bus.oeb, 1);
    chk("rst_addr", bus.addr, 0);
    chk("rst_idata", bus.idata, 0);
    chk("rst_bist", {bus.bist_en, bus.bist_mode, bus.bist_done, bus.bist_ok}, 0);
    chk("rst_hs", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.rdata}, 0);

    // 1: R0 write then read of 0x0010
    bus.r0_req = 1; bus.r0_we = 1; bus.r0_addr = 16'h0010; bus.r0_wdata = 8'h5A;
    tick();
    chk("t1w_gnt", {bus.r0_gnt, bus.r1_gnt}, 2'b10);
    chk("t1w_strb", {bus.ce, bus.csb, bus.web, bus.oeb}, 4'b1001);
    chk("t1w_addr", bus.addr, 16'h0010);
    chk("t1w_idata", bus.idata, 8'h5A);
    bus.r0_req = 0;
    tick();
    chk("t1w_ce_off", {bus.ce, bus.csb, bus.r0_gnt}, 3'b010);
    bus.r0_req = 1; bus.r0_we = 0;
    tick();
    chk("t1r_gnt", bus.r0_gnt, 1);
    chk("t1r_strb", {bus.ce, bus.csb, bus.web, bus.oeb}, 4'b1010);
    bus.r0_req = 0;
    tick();
    chk("t1r_wait", {bus.ce, bus.csb, bus.oeb, bus.r0_rvalid}, 4'b0100);
    tick();
    chk("t1r_rvalid", {bus.r0_rvalid, bus.r1_rvalid, bus.oeb}, 3'b101);
    chk("t1r_rdata", bus.rdata, 8'h5A);
    tick();
    chk("t1r_rvalid_pulse", bus.r0_rvalid, 0);

    // 2: both requesters hold read requests for 6 accesses
    reset_dut();
    bus.r0_req = 1; bus.r0_we = 0; bus.r0_addr = 16'h0010;
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = 16'h0020;
    ng = 0;
    nv = 0;
    for (int c = 0; c < 60 && nv < 6; c++) begin
      tick();
      if (bus.r0_gnt || bus.r1_gnt) begin
`ifdef MEMARB_FIXED_PRI_EN
        exp_r1 = 1'b0;
`else
        exp_r1 = (ng % 2 == 1);
`endif
        chk("t2_gnt_order", {bus.r0_gnt, bus.r1_gnt}, {~exp_r1, exp_r1});
        q.push_back(exp_r1);
        ng++;
        if (ng == 6) begin
          bus.r0_req = 0;
          bus.r1_req = 0;
        end
      end
      if (bus.r0_rvalid || bus.r1_rvalid) begin
        if (q.size() > 0) exp_r1 = q.pop_front();
        else exp_r1 = 1'bx;
        chk("t2_rvalid_dest", {bus.r0_rvalid, bus.r1_rvalid}, {~exp_r1, exp_r1});
        chk("t2_rdata", bus.rdata, exp_r1 ? 8'h85 : 8'h5A);
        nv++;
      end
    end
    chk("t2_rvalid_count", nv, 6);
    tick();

    // 3: BIST request arrives during an R1 read access
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = 16'h0020;
    tick();
    chk("t3_r1_gnt", {bus.r0_gnt, bus.r1_gnt}, 2'b01);
    bus.r1_req = 0;
    bus.bist_req = 1; bus.bist_mode_in = 3'b001;
    bus.r0_req = 1; bus.r0_we = 0; bus.r0_addr = 16'h0010;
    tick();
    chk("t3_wait_no_bist", bus.bist_en, 0);
    tick();
    chk("t3_r1_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b01);
    chk("t3_r1_rdata", bus.rdata, 8'h85);
    tick();
    chk("t3_bist_on", {bus.bist_en, bus.bist_mode}, 4'b1001);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_r0_blocked", {bus.r0_gnt, bus.ce, bus.csb, bus.bist_en}, 4'b0011);
    end
    bus.bist_pass = 1;
    bus.bist_req = 0;
    tick();
    chk("t3_done", {bus.bist_done, bus.bist_ok, bus.bist_en, bus.bist_mode}, 6'b110000);
    tick();
    chk("t3_r0_after", {bus.r0_gnt, bus.bist_done, bus.ce}, 3'b101);
    bus.r0_req = 0;
    tick();
    tick();
    chk("t3_r0_rvalid", bus.r0_rvalid, 1);

    // 4: BIST_OK follows BIST_PASS sampled at session end
    bus.bist_req = 1; bus.bist_mode_in = 3'b110;
    tick();
    tick();
    chk("t4_mode", bus.bist_mode, 3'b110);
    bus.bist_pass = 0; bus.bist_req = 0;
    tick();
    chk("t4_fail_ok", {bus.bist_done, bus.bist_ok}, 2'b10);
    bus.bist_pass = 1;
    tick();
    chk("t4_ok_held", {bus.bist_done, bus.bist_ok}, 2'b00);
    bus.bist_req = 1;
    tick();
    tick();
    bus.bist_req = 0;
    tick();
    chk("t4_pass_ok", {bus.bist_done, bus.bist_ok}, 2'b11);

    // 5: reset while a read is waiting
    bus.r0_req = 1; bus.r0_we = 0; bus.r0_addr = 16'h0010;
    tick();
    chk("t5_gnt", bus.r0_gnt, 1);
    bus.r0_req = 0;
    tick();
    chk("t5_rdwait", bus.oeb, 0);
    rst = 1;
    tick();
    chk("t5_rst_strb", {bus.ce, bus.csb, bus.web, bus.oeb, bus.r0_rvalid}, 5'b01110);
    rst = 0;
    tick();
    chk("t5_no_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b00);
    bus.r0_req = 1; bus.r0_we = 1; bus.r0_wdata = 8'h11;
    bus.r1_req = 1; bus.r1_we = 1; bus.r1_addr = 16'h0030; bus.r1_wdata = 8'h22;
    tick();
    chk("t5_tie_r0", {bus.r0_gnt, bus.r1_gnt}, 2'b10);
    bus.r0_req = 0;
    tick();
    tick();
    chk("t5_then_r1", {bus.r0_gnt, bus.r1_gnt}, 2'b01);
    chk("t5_r1_addr", bus.addr, 16'h0030);
    bus.r1_req = 0;
    tick();

    // 6: RD_LAT=3 instance, R1 read
    bus3.r1_req = 1;
    tick();
    chk("t6_gnt", {bus3.r1_gnt, bus3.oeb, bus3.ce}, 3'b101);
    bus3.r1_req = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_oeb_low", {bus3.oeb, bus3.ce, bus3.r1_rvalid}, 3'b000);
    end
    tick();
    chk("t6_rvalid", {bus3.oeb, bus3.r1_rvalid, bus3.r0_rvalid}, 3'b110);
    chk("t6_rdata", bus3.rdata, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
